cpu_step_control: RTL and testbench

Front-panel input controller for the multicycle CPU board top. It synchronizes and debounces the pause and step pushbuttons. It runs a RUN/HALT state machine and issues single-clock CPU enable pulses: periodic in RUN, one per step press in HALT. This replaces the free-running toggled slow clock, so the whole CPU runs on `clk` gated by `cpu_en`. It also supplies a step counter that the seven-segment mux can display.

---
 rtl/cpu_ctrl_pkg.sv | 24 ++
 rtl/cpu_step_control_if.sv | 37 +++
 rtl/cpu_step_control_btn_debounce.sv | 62 ++++++
 rtl/cpu_step_control.sv | 106 ++++++++++
 tb/tb_cpu_step_control.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the front-panel step controller.
// Imported by the controller RTL, the board top and the CPU testbench so that
// everyone agrees on the RUN/HALT encoding and the default timing constants.
//   run_state_t  : controller mode (RUN = free-running ticks, HALT = single-step)
//   ctrl_dbg_t   : debug view of the controller (FSM state + debounced levels)
package cpu_ctrl_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } run_state_t;

    // 1 s between enable pulses and 10 ms debounce at a 100 MHz board clock.
    localparam int TICK_DIV_DEFAULT  = 100_000_000;
    localparam int DB_CYCLES_DEFAULT = 1_000_000;
    localparam int CNT_W_DEFAULT     = 32;

    typedef struct packed {
        run_state_t state;
        logic       pause_stable;
        logic       step_stable;
    } ctrl_dbg_t;

endpackage

// File: rtl/cpu_step_control_if.sv
// Front-panel bundle between the board (buttons, CPU, display) and the
// step controller.
//   btn_pause, btn_step : raw asynchronous pushbuttons (board -> controller)
//   cpu_en              : one-clock CPU enable strobe (controller -> board)
//   running             : 1 in RUN, 0 in HALT
//   step_count          : number of cpu_en pulses since reset
// Handshake: there is no valid/ready pair on this bundle. cpu_en is a
// registered strobe that is high for exactly one clk cycle per CPU step and
// is never high in two consecutive cycles; consumers sample it on clk and
// must not stall it. The buttons are level inputs with no timing contract.
interface cpu_step_control_if #(
    parameter int CNT_W = 32
);
    logic             btn_pause;
    logic             btn_step;
    logic             cpu_en;
    logic             running;
    logic [CNT_W-1:0] step_count;

    // master: the board side that owns the buttons and consumes the strobe.
    modport master (
        output btn_pause,
        output btn_step,
        input  cpu_en,
        input  running,
        input  step_count
    );

    // slave: the step controller.
    modport slave (
        input  btn_pause,
        input  btn_step,
        output cpu_en,
        output running,
        output step_count
    );
endinterface

// File: rtl/cpu_step_control_btn_debounce.sv
// Pushbutton conditioner: two-flop synchronizer, debounce filter and
// registered rising-edge press pulse.
//   clk, reset : system clock, synchronous active-high reset
//   raw        : asynchronous button level
//   stable     : debounced level (changes only after DB_CYCLES agreeing clocks)
//   press      : one-clock pulse the cycle after stable rises
module btn_debounce
    import cpu_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic press
);
    // +1 keeps the counter at least one bit wide when DB_CYCLES is 1.
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync_a;
    logic          sync_b;
    logic          stable_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // cnt holds how many consecutive clocks sync_b has disagreed with stable;
    // the DB_CYCLES-th disagreeing clock commits the new level.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync_b == stable) begin
            cnt <= '0;
        end else if (cnt == CW'(DB_CYCLES - 1)) begin
            cnt    <= '0;
            stable <= sync_b;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d <= 1'b0;
            press    <= 1'b0;
        end else begin
            stable_d <= stable;
            press    <= stable & ~stable_d;
        end
    end

endmodule

// File: rtl/cpu_step_control.sv
// Front-panel step controller: RUN/HALT mode machine driving a one-clock CPU
// enable. RUN issues a pulse every TICK_DIV+1 clocks (TICK_DIV counting clocks
// plus the issue clock); HALT issues one pulse per debounced step press.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : front-panel bundle (buttons in; cpu_en, running, step_count out)
//   dbg        : FSM state and debounced button levels for observation
module cpu_step_control
    import cpu_ctrl_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEFAULT,   // >= 2
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,  // >= 1
    parameter int CNT_W     = CNT_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    cpu_step_control_if.slave        bus,
    output ctrl_dbg_t                dbg
);
    localparam int TCW = $clog2(TICK_DIV);

    run_state_t       state_q;
    run_state_t       state_d;
    logic             pause_stable;
    logic             pause_press;
    logic             step_stable;
    logic             step_press;
    logic [TCW-1:0]   tick_cnt;
    logic             tick_pend;
    logic             cpu_en_d;
    logic             cpu_en_q;
    logic [CNT_W-1:0] step_count_q;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_pause (
        .clk    (clk),
        .reset  (reset),
        .raw    (bus.btn_pause),
        .stable (pause_stable),
        .press  (pause_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step (
        .clk    (clk),
        .reset  (reset),
        .raw    (bus.btn_step),
        .stable (step_stable),
        .press  (step_press)
    );

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    // ---- FSM: next state ---- every pause press toggles the mode.
    always_comb begin
        state_d = state_q;
        if (pause_press) state_d = (state_q == RUN) ? HALT : RUN;
    end

    // ---- FSM: outputs ---- a pause press in the same cycle wins over a
    // pending tick or a step press, so mode changes never emit a pulse.
    always_comb begin
        cpu_en_d = 1'b0;
        unique case (state_q)
            RUN:  cpu_en_d = tick_pend && !pause_press;
            HALT: cpu_en_d = step_press && !pause_press;
        endcase
    end

    // Tick counter: 0..TICK_DIV-1, then one clock with tick_pend set while
    // the pulse is issued; the counter holds during that clock.
    always_ff @(posedge clk) begin
        if (reset || pause_press || state_q != RUN) begin
            tick_cnt  <= '0;
            tick_pend <= 1'b0;
        end else if (tick_pend) begin
            tick_pend <= 1'b0;
        end else if (tick_cnt == TCW'(TICK_DIV - 1)) begin
            tick_cnt  <= '0;
            tick_pend <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + TCW'(1);
        end
    end

    // step_count lags cpu_en by one clock so it matches the post-step CPU state.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_en_q     <= 1'b0;
            step_count_q <= '0;
        end else begin
            cpu_en_q <= cpu_en_d;
            if (cpu_en_q) step_count_q <= step_count_q + CNT_W'(1);
        end
    end

    assign bus.cpu_en     = cpu_en_q;
    assign bus.running    = (state_q == RUN);
    assign bus.step_count = step_count_q;

    assign dbg.state        = state_q;
    assign dbg.pause_stable = pause_stable;
    assign dbg.step_stable  = step_stable;

endmodule

// File: tb/tb_cpu_step_control.sv
// Bench for cpu_step_control with TICK_DIV=8, DB_CYCLES=4, CNT_W=4.
// The reference model works from edge-indexed button samples: a level is
// accepted when the last DB_CYCLES synchronized samples all disagree with it,
// presses take effect two edges later, and RUN ticks are scheduled every
// TICK_DIV+1 edges from the last mode entry.
module tb_cpu_step_control;
    import cpu_ctrl_pkg::*;

    localparam int TD = 8;
    localparam int DB = 4;
    localparam int CW = 4;

    logic      clk;
    logic      reset;
    ctrl_dbg_t dbg;

    cpu_step_control_if #(.CNT_W(CW)) bus ();

    cpu_step_control #(.TICK_DIV(TD), .DB_CYCLES(DB), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .dbg   (dbg)
    );

    // ---- clock / reset ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- bookkeeping ----
    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    // ---- reference model state ----
    bit          raw_p_q[$];
    bit          raw_s_q[$];
    bit          rst_q[$];
    int          rst_last = -100;
    bit          m_run;
    bit          m_en;
    logic [CW-1:0] m_cnt;
    bit          st_p, st_s;
    int          acc_p, acc_s;
    int          fx_p[$], fx_s[$];
    int          next_tick;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d edge=%0d", tag, obs, exp, edge_n);
        end
    endtask

    // Synchronized level the debouncer compares at edge j: the raw value
    // sampled two edges earlier, or 0 if that sample precedes reset release.
    function automatic bit sync_val(input bit is_step, input int j);
        if (j - 2 <= rst_last) return 1'b0;
        return is_step ? raw_s_q[j-2] : raw_p_q[j-2];
    endfunction

    function automatic bit window_flip(input bit is_step, input bit stable, input int acc, input int k);
        if (k - DB + 1 <= acc) return 1'b0;
        for (int j = k - DB + 1; j <= k; j++)
            if (sync_val(is_step, j) == stable) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(input int k);
        bit prev_en;
        bit pause_now;
        bit step_now;
        if (rst_q[k]) begin
            rst_last  = k;
            m_run     = 1'b1;
            m_en      = 1'b0;
            m_cnt     = '0;
            st_p      = 1'b0;
            st_s      = 1'b0;
            acc_p     = k;
            acc_s     = k;
            fx_p.delete();
            fx_s.delete();
            next_tick = k + TD + 1;
            return;
        end
        prev_en   = m_en;
        pause_now = 1'b0;
        step_now  = 1'b0;
        if (fx_p.size() > 0 && fx_p[0] == k) begin pause_now = 1'b1; void'(fx_p.pop_front()); end
        if (fx_s.size() > 0 && fx_s[0] == k) begin step_now = 1'b1; void'(fx_s.pop_front()); end
        if (window_flip(1'b0, st_p, acc_p, k)) begin
            st_p = !st_p; acc_p = k;
            if (st_p) fx_p.push_back(k + 2);
        end
        if (window_flip(1'b1, st_s, acc_s, k)) begin
            st_s = !st_s; acc_s = k;
            if (st_s) fx_s.push_back(k + 2);
        end
        if (pause_now) begin
            m_run = !m_run;
            m_en  = 1'b0;
            if (m_run) next_tick = k + TD + 1;
        end else if (m_run) begin
            m_en = (k == next_tick);
            if (m_en) next_tick = next_tick + TD + 1;
        end else begin
            m_en = step_now;
        end
        if (prev_en) m_cnt = m_cnt + CW'(1);
    endtask

    task automatic check_all();
        check("cpu_en", 32'(bus.cpu_en), 32'(m_en));
        check("running", 32'(bus.running), 32'(m_run));
        check("step_count", 32'(bus.step_count), 32'(m_cnt));
        check("state", 32'(dbg.state), 32'(m_run ? RUN : HALT));
        check("pause_stable", 32'(dbg.pause_stable), 32'(st_p));
        check("step_stable", 32'(dbg.step_stable), 32'(st_s));
    endtask

    // ---- driver: record what the edge will sample, clock, then check ----
    task automatic tick();
        raw_p_q.push_back(bus.btn_pause);
        raw_s_q.push_back(bus.btn_step);
        rst_q.push_back(reset);
        @(posedge clk);
        #1;
        model_edge(edge_n);
        check_all();
        edge_n++;
    endtask

    // ---- directed + random sequence ----
    initial begin
        int n_en;
        int last_en;
        int wraps;
        logic [CW-1:0] prev_cnt;
        int seg_len;

        bus.btn_pause = 1'b0;
        bus.btn_step  = 1'b0;
        reset         = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // Free-running ticks after reset: pulses 9, 18, 27 edges after release.
        for (int i = 1; i <= 30; i++) begin
            tick();
            check("reset_tick_edge", 32'(bus.cpu_en), 32'(i == 9 || i == 18 || i == 27));
            check("reset_running", 32'(bus.running), 32'd1);
        end
        check("count_after_three", 32'(bus.step_count), 32'd3);

        // Pause held 10 clocks: HALT takes effect DB+4 edges after the press.
        bus.btn_pause = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("pause_running", 32'(bus.running), 32'(i < DB + 4));
        end
        bus.btn_pause = 1'b0;
        n_en = 0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (bus.cpu_en) n_en++;
        end
        check("halt_no_pulses", 32'(n_en), 32'd0);
        check("halt_count_frozen", 32'(bus.step_count), 32'd4);

        // Step held 10 clocks in HALT: exactly one pulse, DB+4 edges after press.
        bus.btn_step = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 10) bus.btn_step = 1'b0;
            check("step_pulse_edge", 32'(bus.cpu_en), 32'(i == DB + 4));
        end
        check("step_count_plus1", 32'(bus.step_count), 32'd5);

        // Step glitch shorter than DB_CYCLES: no pulse.
        bus.btn_step = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (i == DB - 1) bus.btn_step = 1'b0;
            check("glitch_no_pulse", 32'(bus.cpu_en), 32'd0);
        end

        // Pause and step together in HALT: resume wins, step dropped,
        // first tick TICK_DIV+1 edges after the resume edge.
        bus.btn_pause = 1'b1;
        bus.btn_step  = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 10) begin
                bus.btn_pause = 1'b0;
                bus.btn_step  = 1'b0;
            end
            check("resume_running", 32'(bus.running), 32'(i >= DB + 4));
            check("resume_pulse_edge", 32'(bus.cpu_en),
                  32'(i == DB + 4 + TD + 1 || i == DB + 4 + 2 * (TD + 1)));
        end

        // Step pressed in RUN: ignored, spacing stays TICK_DIV+1.
        bus.btn_step = 1'b1;
        last_en = -1;
        n_en = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 10) bus.btn_step = 1'b0;
            if (bus.cpu_en) begin
                if (last_en >= 0) check("run_tick_gap", 32'(i - last_en), 32'(TD + 1));
                last_en = i;
                n_en++;
            end
        end
        check("run_tick_count", 32'(n_en), 32'd4);

        // Long RUN stretch: step_count wraps 15 -> 0.
        wraps = 0;
        for (int i = 1; i <= 160; i++) begin
            prev_cnt = bus.step_count;
            tick();
            if (prev_cnt == '1 && bus.step_count == '0) wraps++;
        end
        check("wrap_seen", 32'(wraps), 32'd1);

        // Reset mid-tick.
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_cpu_en", 32'(bus.cpu_en), 32'd0);
        check("midreset_count", 32'(bus.step_count), 32'd0);
        check("midreset_running", 32'(bus.running), 32'd1);
        repeat (5) tick();

        // Pause held through reset: accepted as a fresh press after release.
        bus.btn_pause = 1'b1;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("held_stable", 32'(dbg.pause_stable), 32'(i >= DB + 2));
            check("held_running", 32'(bus.running), 32'(i < DB + 4));
        end
        bus.btn_pause = 1'b0;
        repeat (10) tick();

        // Random button activity, long and short holds mixed.
        for (int seg = 0; seg < 60; seg++) begin
            bus.btn_pause = ($urandom_range(0, 3) == 0);
            bus.btn_step  = ($urandom_range(0, 1) == 1);
            seg_len = $urandom_range(1, 12);
            repeat (seg_len) tick();
        end
        bus.btn_pause = 1'b0;
        bus.btn_step  = 1'b0;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
